inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 188 ++++++++++++++++++
 tb/tb_inst_fetch.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch unit: requests one instruction at a time from instruction
// memory, holds it for decode and stalls the PC until it is accepted. Fetching
// stops permanently on a halt word or on a memory timeout; only rst restarts it.
module inst_fetch #(
    parameter logic [31:0] HALT_WORD = 32'hFC000000,
    parameter logic [7:0]  TIMEOUT   = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic        pc_stall,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        halted,
    output logic        fetch_err
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_DISCARD = 3'd2,
        ST_HOLD    = 3'd3,
        ST_HALTED  = 3'd4,
        ST_ERR     = 3'd5
    } state_t;

    state_t      state_r, state_s;
    logic        imem_req_r, imem_req_s;
    logic [31:0] imem_addr_r, imem_addr_s;
    logic [31:0] instr_r, instr_s;
    logic [31:0] instr_pc_r, instr_pc_s;
    logic        instr_valid_r, instr_valid_s;
    logic        halted_r, halted_s;
    logic        fetch_err_r, fetch_err_s;
    logic [7:0]  timeout_cnt_r, timeout_cnt_s;
    logic        stall_s;
    logic        timeout_hit_s;

    // The outstanding request has waited its last permitted cycle.
    always_comb begin
        timeout_hit_s = (timeout_cnt_r == (TIMEOUT - 8'd1));
    end

    // Next-state, next-register values and the combinational PC hold.
    always_comb begin
        state_s       = state_r;
        imem_req_s    = imem_req_r;
        imem_addr_s   = imem_addr_r;
        instr_s       = instr_r;
        instr_pc_s    = instr_pc_r;
        instr_valid_s = instr_valid_r;
        halted_s      = halted_r;
        fetch_err_s   = fetch_err_r;
        timeout_cnt_s = timeout_cnt_r;
        stall_s       = 1'b1;
        case (state_r)
            ST_IDLE: begin
                if (flush) begin
                    // Let the PC take the redirect; capture it next cycle.
                    stall_s = 1'b0;
                    state_s = ST_IDLE;
                end else begin
                    imem_addr_s   = pc;
                    imem_req_s    = 1'b1;
                    timeout_cnt_s = 8'd0;
                    state_s       = ST_REQ;
                end
            end
            ST_REQ: begin
                if (imem_ack) begin
                    imem_req_s    = 1'b0;
                    timeout_cnt_s = 8'd0;
                    if (flush) begin
                        // Data arriving together with a redirect is stale.
                        stall_s = 1'b0;
                        state_s = ST_IDLE;
                    end else begin
                        instr_s       = imem_rdata;
                        instr_pc_s    = imem_addr_r;
                        instr_valid_s = 1'b1;
                        state_s       = ST_HOLD;
                    end
                end else if (timeout_hit_s) begin
                    imem_req_s  = 1'b0;
                    fetch_err_s = 1'b1;
                    state_s     = ST_ERR;
                end else begin
                    timeout_cnt_s = timeout_cnt_r + 8'd1;
                    if (flush) begin
                        state_s = ST_DISCARD;
                    end else begin
                        state_s = ST_REQ;
                    end
                end
            end
            ST_DISCARD: begin
                // The request cannot be withdrawn, so wait it out and drop it.
                if (imem_ack) begin
                    imem_req_s    = 1'b0;
                    timeout_cnt_s = 8'd0;
                    stall_s       = 1'b0;
                    state_s       = ST_IDLE;
                end else if (timeout_hit_s) begin
                    imem_req_s  = 1'b0;
                    fetch_err_s = 1'b1;
                    state_s     = ST_ERR;
                end else begin
                    timeout_cnt_s = timeout_cnt_r + 8'd1;
                    state_s       = ST_DISCARD;
                end
            end
            ST_HOLD: begin
                if (flush) begin
                    stall_s       = 1'b0;
                    instr_valid_s = 1'b0;
                    state_s       = ST_IDLE;
                end else if (instr_ready) begin
                    instr_valid_s = 1'b0;
                    if (instr_r == HALT_WORD) begin
                        halted_s = 1'b1;
                        state_s  = ST_HALTED;
                    end else begin
                        stall_s = 1'b0;
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_HOLD;
                end
            end
            ST_HALTED, ST_ERR: begin
                imem_req_s    = 1'b0;
                instr_valid_s = 1'b0;
            end
            default: begin
                imem_req_s    = 1'b0;
                instr_valid_s = 1'b0;
                state_s       = ST_IDLE;
            end
        endcase
        if (rst) begin
            stall_s = 1'b1;
        end else begin
            stall_s = stall_s;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            imem_req_r    <= 1'b0;
            imem_addr_r   <= 32'd0;
            instr_r       <= 32'd0;
            instr_pc_r    <= 32'd0;
            instr_valid_r <= 1'b0;
            halted_r      <= 1'b0;
            fetch_err_r   <= 1'b0;
            timeout_cnt_r <= 8'd0;
        end else begin
            state_r       <= state_s;
            imem_req_r    <= imem_req_s;
            imem_addr_r   <= imem_addr_s;
            instr_r       <= instr_s;
            instr_pc_r    <= instr_pc_s;
            instr_valid_r <= instr_valid_s;
            halted_r      <= halted_s;
            fetch_err_r   <= fetch_err_s;
            timeout_cnt_r <= timeout_cnt_s;
        end
    end

    assign pc_stall    = stall_s;
    assign imem_req    = imem_req_r;
    assign imem_addr   = imem_addr_r;
    assign instr       = instr_r;
    assign instr_pc    = instr_pc_r;
    assign instr_valid = instr_valid_r;
    assign halted      = halted_r;
    assign fetch_err   = fetch_err_r;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed self-checking bench for inst_fetch with a small PC-register model.
module tb_inst_fetch;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        pc_stall;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        halted;
    logic        fetch_err;

    int checks;
    int errors;
    logic seen_req;
    logic seen_unstall;

    inst_fetch #(
        .HALT_WORD(32'hFC000000),
        .TIMEOUT  (8'd4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pc         (pc),
        .pc_stall   (pc_stall),
        .flush      (flush),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .halted     (halted),
        .fetch_err  (fetch_err)
    );

    // Free-running clock, 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // PC register model: advances by one word whenever the fetch unit releases it.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= 32'd0;
        end else if (!pc_stall) begin
            pc <= pc + 32'd4;
        end else begin
            pc <= pc;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; flush = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0; instr_ready = 1'b0;
        cyc(); cyc();
        settle();
        check_eq("rst_req", {31'd0, imem_req}, 32'd0);
        check_eq("rst_addr", imem_addr, 32'd0);
        check_eq("rst_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("rst_flags", {30'd0, halted, fetch_err}, 32'd0);
        check_eq("rst_stall", {31'd0, pc_stall}, 32'd1);

        // Basic fetch at pc 0, ack after two REQ cycles.
        rst = 1'b0; settle();
        check_eq("idle_stall", {31'd0, pc_stall}, 32'd1);
        check_eq("idle_noreq", {31'd0, imem_req}, 32'd0);
        cyc(); settle();
        check_eq("req0_req", {31'd0, imem_req}, 32'd1);
        check_eq("req0_addr", imem_addr, 32'd0);
        check_eq("req0_stall", {31'd0, pc_stall}, 32'd1);
        cyc();
        imem_ack = 1'b1; imem_rdata = 32'h20010005; settle();
        check_eq("req1_stall", {31'd0, pc_stall}, 32'd1);
        cyc();
        imem_ack = 1'b0; instr_ready = 1'b1; settle();
        check_eq("b_valid", {31'd0, instr_valid}, 32'd1);
        check_eq("b_instr", instr, 32'h20010005);
        check_eq("b_ipc", instr_pc, 32'd0);
        check_eq("b_unstall", {31'd0, pc_stall}, 32'd0);
        cyc();
        instr_ready = 1'b0; settle();
        check_eq("b_valid_clr", {31'd0, instr_valid}, 32'd0);
        check_eq("b_restall", {31'd0, pc_stall}, 32'd1);
        cyc(); settle();
        check_eq("b_next_addr", imem_addr, 32'd4);
        check_eq("b_next_req", {31'd0, imem_req}, 32'd1);

        // Decode back-pressure for five cycles, accept on the sixth.
        imem_ack = 1'b1; imem_rdata = 32'h11112222;
        cyc();
        imem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            settle();
            check_eq("bp_valid", {31'd0, instr_valid}, 32'd1);
            check_eq("bp_instr", instr, 32'h11112222);
            check_eq("bp_ipc", instr_pc, 32'd4);
            check_eq("bp_stall", {31'd0, pc_stall}, 32'd1);
            cyc();
        end
        instr_ready = 1'b1; settle();
        check_eq("bp_accept", {31'd0, pc_stall}, 32'd0);
        cyc();
        instr_ready = 1'b0; settle();
        check_eq("bp_valid_clr", {31'd0, instr_valid}, 32'd0);
        cyc(); settle();
        check_eq("bp_next_addr", imem_addr, 32'd8);

        // Halt word: accepted without releasing the PC, then terminal.
        imem_ack = 1'b1; imem_rdata = 32'hFC000000;
        cyc();
        imem_ack = 1'b0; instr_ready = 1'b1; settle();
        check_eq("h_valid", {31'd0, instr_valid}, 32'd1);
        check_eq("h_stall", {31'd0, pc_stall}, 32'd1);
        cyc();
        instr_ready = 1'b0; settle();
        check_eq("h_halted", {31'd0, halted}, 32'd1);
        check_eq("h_valid_clr", {31'd0, instr_valid}, 32'd0);
        seen_req = 1'b0; seen_unstall = 1'b0;
        for (int i = 0; i < 20; i++) begin
            flush = (i % 3 == 0); imem_ack = (i % 2 == 0); instr_ready = (i % 5 == 0);
            settle();
            seen_req = seen_req | imem_req;
            seen_unstall = seen_unstall | ~pc_stall;
            cyc();
        end
        flush = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0; settle();
        check_eq("h_no_req", {31'd0, seen_req}, 32'd0);
        check_eq("h_no_unstall", {31'd0, seen_unstall}, 32'd0);
        check_eq("h_sticky", {31'd0, halted}, 32'd1);
        check_eq("h_pc_held", pc, 32'd8);

        // Reset out of halt, then flush in the first REQ cycle.
        rst = 1'b1; settle();
        check_eq("rst_hi_stall", {31'd0, pc_stall}, 32'd1);
        cyc();
        rst = 1'b0; settle();
        check_eq("rst_halt_clr", {31'd0, halted}, 32'd0);
        cyc();
        flush = 1'b1; settle();
        check_eq("f_req", {31'd0, imem_req}, 32'd1);
        check_eq("f_stall", {31'd0, pc_stall}, 32'd1);
        cyc();
        flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            settle();
            check_eq("f_disc_req", {31'd0, imem_req}, 32'd1);
            check_eq("f_disc_stall", {31'd0, pc_stall}, 32'd1);
            cyc();
        end
        imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF; settle();
        check_eq("f_ack_unstall", {31'd0, pc_stall}, 32'd0);
        cyc();
        imem_ack = 1'b0; settle();
        check_eq("f_no_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("f_instr_dropped", instr, 32'd0);
        cyc(); settle();
        check_eq("f_new_addr", imem_addr, 32'd4);

        // No ack: error after four REQ cycles.
        for (int i = 0; i < 4; i++) begin
            settle();
            check_eq("t_req", {31'd0, imem_req}, 32'd1);
            cyc();
        end
        settle();
        check_eq("t_err", {31'd0, fetch_err}, 32'd1);
        check_eq("t_req_off", {31'd0, imem_req}, 32'd0);
        imem_ack = 1'b1; flush = 1'b1; instr_ready = 1'b1; settle();
        check_eq("t_err_stall", {31'd0, pc_stall}, 32'd1);
        cyc(); cyc();
        imem_ack = 1'b0; flush = 1'b0; instr_ready = 1'b0; settle();
        check_eq("t_err_sticky", {31'd0, fetch_err}, 32'd1);
        check_eq("t_err_valid", {31'd0, instr_valid}, 32'd0);
        rst = 1'b1;
        cyc();
        rst = 1'b0; settle();
        check_eq("t_rst_err", {31'd0, fetch_err}, 32'd0);
        check_eq("t_rst_req", {31'd0, imem_req}, 32'd0);
        check_eq("t_rst_addr", imem_addr, 32'd0);
        check_eq("t_rst_stall", {31'd0, pc_stall}, 32'd1);
        cyc(); settle();
        check_eq("t_restart_req", {31'd0, imem_req}, 32'd1);
        check_eq("t_restart_addr", imem_addr, 32'd0);

        // Reset while holding a valid instruction, late ack ignored.
        imem_ack = 1'b1; imem_rdata = 32'h01234567;
        cyc();
        imem_ack = 1'b0; settle();
        check_eq("r_valid", {31'd0, instr_valid}, 32'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0; imem_ack = 1'b1; settle();
        check_eq("r_valid_clr", {31'd0, instr_valid}, 32'd0);
        check_eq("r_instr_clr", instr, 32'd0);
        check_eq("r_stall", {31'd0, pc_stall}, 32'd1);
        cyc();
        imem_ack = 1'b0; settle();
        check_eq("r_late_ack", {31'd0, instr_valid}, 32'd0);
        check_eq("r_req", {31'd0, imem_req}, 32'd1);

        // Flush and ack in the same REQ cycle.
        imem_ack = 1'b1; flush = 1'b1; imem_rdata = 32'hAAAA5555; settle();
        check_eq("fa_unstall", {31'd0, pc_stall}, 32'd0);
        cyc();
        imem_ack = 1'b0; flush = 1'b0; settle();
        check_eq("fa_no_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("fa_idle", {31'd0, imem_req}, 32'd0);
        cyc(); settle();
        check_eq("fa_addr", imem_addr, 32'd4);

        // Flush beats instr_ready in HOLD, even on a halt word.
        imem_ack = 1'b1; imem_rdata = 32'hFC000000;
        cyc();
        imem_ack = 1'b0; instr_ready = 1'b1; flush = 1'b1; settle();
        check_eq("fh_unstall", {31'd0, pc_stall}, 32'd0);
        cyc();
        instr_ready = 1'b0; flush = 1'b0; settle();
        check_eq("fh_valid_clr", {31'd0, instr_valid}, 32'd0);
        check_eq("fh_not_halted", {31'd0, halted}, 32'd0);

        // Flush in IDLE releases the PC and stays idle.
        flush = 1'b1; settle();
        check_eq("fi_unstall", {31'd0, pc_stall}, 32'd0);
        cyc();
        flush = 1'b0; settle();
        check_eq("fi_idle", {31'd0, imem_req}, 32'd0);
        cyc(); settle();
        check_eq("fi_addr", imem_addr, 32'd12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
